// File: rtl/wd_pkg.sv
// Shared constants and types for the write-data serializer.
package wd_pkg;

    localparam int WIDTH   = 64;
    localparam int WAYS    = 8;
    localparam int LANE_W  = WIDTH / WAYS;
    localparam int DEPTH   = 4;
    localparam int SKID    = 2;
    localparam int LANE_IW = $clog2(WAYS);

    // One write-data beat viewed as WAYS lanes, lane 0 in the low bits.
    typedef logic [WAYS-1:0][LANE_W-1:0] beat_t;

    // Index of a lane within a beat.
    typedef logic [LANE_IW-1:0] lane_t;

    // Extract lane k from a beat.
    function automatic logic [LANE_W-1:0] lane_of(input beat_t b, input lane_t k);
        return b[k];
    endfunction

endpackage

// File: rtl/wd_fifo.sv
// Generic DEPTH x WIDTH FIFO, no read bypass: a word written at edge t is
// visible on rdata from cycle t+1. The caller must never push while full
// unless it pops in the same cycle.
module wd_fifo
    import wd_pkg::*;
#(
    parameter int WIDTH = wd_pkg::WIDTH,
    parameter int DEPTH = wd_pkg::DEPTH
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       push,
    input  logic                       pop,
    input  logic [WIDTH-1:0]           wdata,
    output logic [WIDTH-1:0]           rdata,
    output logic [$clog2(DEPTH):0]     count,
    output logic                       full,
    output logic                       empty
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];

    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q,  count_d;

    // Storage is deliberately left out of reset; only the pointers define contents.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr_q] <= wdata;
        end
    end

    // Pointer and occupancy next-state; pointers wrap naturally at DEPTH.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push) begin
            wr_ptr_d = wr_ptr_q + AW'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
        end
        count_d = count_q + CW'(push) - CW'(pop);
    end

    // Pointer and occupancy registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    assign rdata = mem[rd_ptr_q];
    assign count = count_q;
    assign full  = (count_q == CW'(DEPTH));
    assign empty = (count_q == '0);

endmodule

// File: rtl/wd_serializer.sv
// Buffers whole write-data beats and replays each one as WAYS single-lane
// transfers (lane 0 first) on a valid/ready port. i_r is a credit back to
// the beat source: it drops while SKID or fewer entries are free so beats
// still in flight after it falls can be absorbed.
module wd_serializer
    import wd_pkg::*;
#(
    parameter int WIDTH = wd_pkg::WIDTH,
    parameter int WAYS  = wd_pkg::WAYS,
    parameter int DEPTH = wd_pkg::DEPTH,
    parameter int SKID  = wd_pkg::SKID
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        i_v,
    input  logic [WIDTH-1:0]            i_d,
    output logic                        i_r,
    output logic                        o_v,
    input  logic                        o_r,
    output logic [WIDTH/WAYS-1:0]       o_d,
    output logic [$clog2(WAYS)-1:0]     o_way,
    output logic                        o_last,
    output logic                        o_ovf
);

    localparam int LW  = WIDTH / WAYS;
    localparam int LIW = $clog2(WAYS);
    localparam int CW  = $clog2(DEPTH) + 1;
    localparam logic [LIW-1:0] LAST_LANE = LIW'(WAYS - 1);

    logic [WIDTH-1:0] rd_beat;
    logic [CW-1:0]    count;
    logic             full;
    logic             empty;
    logic             push;
    logic             pop;
    logic             advance;
    logic             drop;

    logic [LIW-1:0]   lane_q, lane_d;
    logic             ovf_q,  ovf_d;

    logic [LW-1:0]    lane_data [WAYS];

    wd_fifo #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (push),
        .pop   (pop),
        .wdata (i_d),
        .rdata (rd_beat),
        .count (count),
        .full  (full),
        .empty (empty)
    );

    // Split the head beat into its lanes.
    for (genvar gi = 0; gi < WAYS; gi++) begin : g_lane
        assign lane_data[gi] = rd_beat[gi*LW +: LW];
    end

    // Handshake decode. A full FIFO still accepts a beat when the last lane
    // of the head beat leaves in the same cycle.
    always_comb begin
        o_v     = !empty;
        o_last  = (lane_q == LAST_LANE);
        pop     = o_v && o_r && o_last;
        advance = o_v && o_r && !o_last;
        push    = i_v && (!full || pop);
        drop    = i_v && full && !pop;
    end

    // Lane counter and sticky overflow next-state.
    always_comb begin
        lane_d = lane_q;
        ovf_d  = ovf_q || drop;
        if (pop) begin
            lane_d = '0;
        end else if (advance) begin
            lane_d = lane_q + LIW'(1);
        end
    end

    // Lane counter and overflow registers; reset abandons any partial beat.
    always_ff @(posedge clk) begin
        if (reset) begin
            lane_q <= '0;
            ovf_q  <= 1'b0;
        end else begin
            lane_q <= lane_d;
            ovf_q  <= ovf_d;
        end
    end

    assign o_d   = lane_data[lane_q];
    assign o_way = lane_q;
    assign o_ovf = ovf_q;
    assign i_r   = ((CW'(DEPTH) - count) > CW'(SKID));

endmodule
